// File: rtl/arm_sequencer.sv
// arm_sequencer: radio stick-gesture arming FSM with frame watchdog.
// Ports: clk, rst_n (sync, active-low), tick_1khz, radio_new,
//   radio_val[39:0] {yaw,thr,pitch,roll}; outputs armed, arm_pulse,
//   disarm_pulse, failsafe (levels/strobes, all registered), state[2:0].
module arm_sequencer #(
  parameter logic [9:0] LOW_TH     = 10'd150,
  parameter logic [9:0] HIGH_TH    = 10'd850,
  parameter int         HOLD_MS    = 1000,
  parameter int         TIMEOUT_MS = 100,
  parameter int         CNT_BITS   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1khz,
  input  logic        radio_new,
  input  logic [39:0] radio_val,
  output logic        armed,
  output logic        arm_pulse,
  output logic        disarm_pulse,
  output logic        failsafe,
  output logic [2:0]  state
);

  localparam logic [2:0] S_DISARMED  = 3'd0;
  localparam logic [2:0] S_ARMING    = 3'd1;
  localparam logic [2:0] S_ARMED     = 3'd2;
  localparam logic [2:0] S_DISARMING = 3'd3;
  localparam logic [2:0] S_LOCKOUT   = 3'd4;

  localparam logic [CNT_BITS-1:0] HOLD_LAST =
    CNT_BITS'(HOLD_MS - 1);
  localparam logic [CNT_BITS-1:0] AGE_MAX =
    CNT_BITS'(TIMEOUT_MS);

  logic [39:0]         r_frame;
  logic [CNT_BITS-1:0] r_age;
  logic [CNT_BITS-1:0] r_hold;
  logic [2:0]          r_state;
  logic                r_armed;
  logic                r_arm_pulse;
  logic                r_disarm_pulse;
  logic                r_failsafe;

  logic [9:0]          w_ch2;
  logic [9:0]          w_ch3;
  logic                w_thr_low;
  logic                w_yaw_hi;
  logic                w_yaw_lo;
  logic                w_centered;
  logic                w_arm_g;
  logic                w_dis_g;
  logic [CNT_BITS-1:0] w_age_nxt;
  logic                w_stale;
  logic [2:0]          w_state_nxt;
  logic [CNT_BITS-1:0] w_hold_nxt;
  logic                w_arm_p;
  logic                w_dis_p;
  logic                w_unused;

  assign w_ch2 = r_frame[29:20];
  assign w_ch3 = r_frame[39:30];
  // roll/pitch are latched with the frame but play no part in gestures
  assign w_unused = ^r_frame[19:0];

  assign w_thr_low  = (w_ch2 < LOW_TH);
  assign w_yaw_hi   = (w_ch3 > HIGH_TH);
  assign w_yaw_lo   = (w_ch3 < LOW_TH);
  assign w_centered = (w_ch3 >= LOW_TH) && (w_ch3 <= HIGH_TH);
  assign w_arm_g    = w_thr_low & w_yaw_hi;
  assign w_dis_g    = w_thr_low & w_yaw_lo;

  // Frame strobe beats a coincident tick; age saturates at timeout.
  always_comb begin
    w_age_nxt = r_age;
    if (radio_new)
      w_age_nxt = '0;
    else if (tick_1khz && (r_age != AGE_MAX))
      w_age_nxt = r_age + 1'b1;
  end

  // Stale is judged on the updated age so failsafe and the forced
  // disarm appear the cycle after the expiring tick.
  assign w_stale = (w_age_nxt == AGE_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_arm_p     = 1'b0;
    w_dis_p     = 1'b0;
    case (r_state)
      S_DISARMED: begin
        w_hold_nxt = '0;
        if (w_arm_g && !w_stale)
          w_state_nxt = S_ARMING;
      end
      S_ARMING: begin
        if (w_stale || !w_arm_g) begin
          w_state_nxt = S_DISARMED;
          w_hold_nxt  = '0;
        end else if (tick_1khz) begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = S_ARMED;
            w_hold_nxt  = '0;
            w_arm_p     = 1'b1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      S_ARMED: begin
        w_hold_nxt = '0;
        if (w_stale) begin
          w_state_nxt = S_LOCKOUT;
          w_dis_p     = 1'b1;
        end else if (w_dis_g) begin
          w_state_nxt = S_DISARMING;
        end
      end
      S_DISARMING: begin
        if (w_stale) begin
          w_state_nxt = S_LOCKOUT;
          w_hold_nxt  = '0;
          w_dis_p     = 1'b1;
        end else if (!w_dis_g) begin
          w_state_nxt = S_ARMED;
          w_hold_nxt  = '0;
        end else if (tick_1khz) begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = S_LOCKOUT;
            w_hold_nxt  = '0;
            w_dis_p     = 1'b1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        w_hold_nxt = '0;
        if (w_centered && w_thr_low && !w_stale)
          w_state_nxt = S_DISARMED;
      end
      default: begin
        w_state_nxt = S_DISARMED;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame        <= '0;
      r_age          <= '0;
      r_hold         <= '0;
      r_state        <= S_DISARMED;
      r_armed        <= 1'b0;
      r_arm_pulse    <= 1'b0;
      r_disarm_pulse <= 1'b0;
      r_failsafe     <= 1'b0;
    end else begin
      if (radio_new)
        r_frame <= radio_val;
      r_age          <= w_age_nxt;
      r_hold         <= w_hold_nxt;
      r_state        <= w_state_nxt;
      r_armed        <= (w_state_nxt == S_ARMED) ||
                        (w_state_nxt == S_DISARMING);
      r_arm_pulse    <= w_arm_p;
      r_disarm_pulse <= w_dis_p;
      r_failsafe     <= w_stale;
    end
  end

  assign armed        = r_armed;
  assign arm_pulse    = r_arm_pulse;
  assign disarm_pulse = r_disarm_pulse;
  assign failsafe     = r_failsafe;
  assign state        = r_state;

endmodule

// File: doc/arm_sequencer.md
# arm_sequencer

Radio arming sequencer for the avionics board. Sits directly downstream of `inputs`, consuming the decoded radio channel words. It produces a debounced, time-qualified `armed` level that gates the ESC `outputs` stage, replacing the edge-toggled motor flag. Arming and disarming require a held stick gesture. A radio-frame watchdog forces disarm (failsafe) when frames stop arriving.

## Interface
Parameters:
- `LOW_TH`, default 10'd150: channel value strictly below this counts as stick low.
- `HIGH_TH`, default 10'd850: channel value strictly above this counts as stick high.
- `HOLD_MS`, default 1000: gesture hold time, in `tick_1khz` strobes.
- `TIMEOUT_MS`, default 100: ticks without `radio_new` before the radio is declared stale.
- `CNT_BITS`, default 11: counter width; must satisfy 2^CNT_BITS > max(HOLD_MS, TIMEOUT_MS).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `tick_1khz`  in  1  one-`clk`-wide strobe at 1 kHz.
- `radio_new`  in  1  one-`clk`-wide strobe marking a fresh frame on `radio_val`.
- `radio_val`  in  40  {ch3 yaw, ch2 throttle, ch1 pitch, ch0 roll}, 10 bits each, ch0 at [9:0].
- `armed`  out  1  motors enabled (level).
- `arm_pulse`  out  1  one-cycle strobe on entry to ARMED.
- `disarm_pulse`  out  1  one-cycle strobe on any exit from ARMED/DISARMING to LOCKOUT.
- `failsafe`  out  1  radio stale (level).
- `state`  out  3  current state code, for debugging.

## Operation
- **Frame latch:** `radio_val` is captured into an internal 40-bit register only on `radio_new`; the latch resets to 0. All gesture decode uses the latch.
- **Decode (combinational, from latch):**
  - `thr_low` = ch2 < LOW_TH
  - `yaw_hi` = ch3 > HIGH_TH
  - `yaw_lo` = ch3 < LOW_TH
  - `centered` = LOW_TH ≤ ch3 ≤ HIGH_TH
  - All comparisons are unsigned.
- **Watchdog:**
  - `age` counter: cleared by `radio_new`; incremented on `tick_1khz`; saturates at TIMEOUT_MS.
  - `stale` = (age == TIMEOUT_MS).
  - `failsafe` is the registered `stale`.
  - `radio_new` and `tick_1khz` in the same cycle: clear wins, so `age` = 0.
- **States (code):**
  - **DISARMED (0):**
    - `hold` = 0.
    - Moves to ARMING if `thr_low && yaw_hi && !stale`.
  - **ARMING (1):**
    - If `stale` or the gesture is lost: go to DISARMED, `hold` = 0.
    - Otherwise, on a tick, `hold` increments.
    - A tick with `hold` == HOLD_MS-1 goes to ARMED and asserts `arm_pulse`.
  - **ARMED (2):**
    - `stale` goes to LOCKOUT and asserts `disarm_pulse`.
    - Otherwise, `thr_low && yaw_lo` goes to DISARMING, `hold` = 0.
  - **DISARMING (3):**
    - `armed` stays 1.
    - `stale`: go to LOCKOUT with `disarm_pulse`.
    - Gesture lost: go back to ARMED.
    - A tick with `hold` == HOLD_MS-1: go to LOCKOUT with `disarm_pulse`.
  - **LOCKOUT (4):**
    - `armed` = 0.
    - Exit to DISARMED when `centered && thr_low && !stale`.
    - This prevents immediate re-arm after failsafe or disarm.
  - **Codes 5–7:** go to DISARMED next cycle; outputs as DISARMED.
- **Priority within a cycle:** `stale`, then gesture loss, then tick/hold completion.
  - Gesture lost on the same cycle as the final tick means abort.

## Timing
- **Registered outputs:** all outputs are registered.
- **`armed`:** 1 exactly in ARMED and DISARMING.
- **Reset:**
  - `rst_n` low at a `clk` edge forces, next cycle: state DISARMED, `hold` = 0, `age` = 0, latch = 0.
  - All outputs 0, including mid-ARMING, mid-DISARMING, or while armed.
- **Arm latency:**
  - Gesture present at cycle N in DISARMED gives state ARMING at N+1.
  - The HOLD_MS-th tick observed in ARMING at cycle M gives `armed` = 1 and `arm_pulse` = 1 at M+1.
  - `arm_pulse` drops at M+2.
- **Disarm latency:** symmetric to arm latency; `armed` = 0 and `disarm_pulse` = 1 in the same cycle.
- **Failsafe latency:** the TIMEOUT_MS-th tick without a frame at cycle T gives `failsafe` = 1 and, if armed, `disarm_pulse` = 1 at T+1.
- **Failsafe clear:** `failsafe` clears one cycle after `radio_new`.
- **Ticks and pulses:** ticks are counted only on `tick_1khz` cycles. Pulses never overlap.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n` low 3 cycles, then release with no frames.
  - Required: all outputs 0, `state` = 0, `failsafe` rises after 100 ticks, no arm.
- **Arm:**
  - Stimulus: frame ch2 = 100, ch3 = 900, frames refreshed every 20 ticks.
  - Required: after exactly 1000 ticks, `armed` = 1 and `arm_pulse` high for 1 cycle.
  - Variant: drop ch3 to 500 at tick 999. Required: `state` = 0, `armed` never rises.
- **Disarm:**
  - Stimulus: while armed, frame ch2 = 100, ch3 = 50 held 1000 ticks.
  - Required: `disarm_pulse` for 1 cycle, `state` = 4.
  - Then frame ch3 = 500, ch2 = 100. Required: `state` = 0.
  - Then re-arm gesture. Required: arms again after 1000 ticks.
- **Failsafe:**
  - Stimulus: armed, stop `radio_new` for 100 ticks.
  - Required: `failsafe` = 1, `armed` = 0, `disarm_pulse`, `state` = 4.
  - Then resume frames with arm gesture. Required: stays in LOCKOUT until a centered, throttle-low frame arrives.
- **Simultaneous events:**
  - Stimulus: `radio_new` coincident with `tick_1khz` at age 99.
  - Required: `age` = 0, no failsafe.
- **Reset mid-operation:**
  - Stimulus: reset at `hold` = 600 in ARMING.
  - Required: `state` = 0.
  - Then the gesture needs a full 1000 ticks to arm.
